// File: rtl/pci_trace_buf.sv
// pci_trace_buf: PCI-clock-domain debug trace of the registered bridge taps with a masked AD trigger.
// Define PCI_TRACE_TIMESTAMP_EN to store a saturating 16-bit timestamp above each sample.
module pci_trace_buf #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 6,
  parameter int POST_TRIG  = 16
) (
  input  logic              pci_clk_i,
  input  logic              pci_rst_i,
  input  logic              pci_irdy_reg_i,
  input  logic              pci_irdy_en_reg_i,
  input  logic              pci_trdy_reg_i,
  input  logic [DATA_W-1:0] pci_ad_reg_i,
  input  logic              arm_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_val_i,
  input  logic              rd_req_i,
`ifdef PCI_TRACE_TIMESTAMP_EN
  output logic [DATA_W+18:0] rd_data_o,
`else
  output logic [DATA_W+2:0]  rd_data_o,
`endif
  output logic              rd_valid_o,
  output logic              rd_empty_o,
  output logic [1:0]        state_o
);

  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int POST_CLAMP = (POST_TRIG > DEPTH - 1) ? DEPTH - 1 : POST_TRIG;
  localparam int SAMPLE_W   = DATA_W + 3;
`ifdef PCI_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W    = SAMPLE_W + 16;
`else
  localparam int ENTRY_W    = SAMPLE_W;
`endif
  localparam logic [DEPTH_LOG2-1:0] POST_LOAD = DEPTH_LOG2'(POST_CLAMP);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   FILL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PRE  = 2'b01,
    POST = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t                state_q;
  logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtrLoad, postCnt_q;
  logic [DEPTH_LOG2:0]   fill_q, fill_d;
  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [ENTRY_W-1:0]    rdData_q;
  logic                  rdValid_q;
  logic [SAMPLE_W-1:0]   sample;
  logic [ENTRY_W-1:0]    entry;
  logic                  dataPhase, trigHit, wrEn, rdFire;
`ifdef PCI_TRACE_TIMESTAMP_EN
  logic [15:0]           tsCnt_q;
`endif

  // fill_q doubles as the unread count once the capture is frozen in DONE.
  always_comb begin
    dataPhase = pci_irdy_en_reg_i & ~pci_irdy_reg_i & ~pci_trdy_reg_i;
    trigHit   = dataPhase && (((pci_ad_reg_i ^ trig_val_i) & trig_mask_i) == '0);
    sample    = {pci_ad_reg_i, pci_irdy_en_reg_i, pci_irdy_reg_i, pci_trdy_reg_i};
    wrEn      = !arm_i && (state_q == PRE || state_q == POST);
    rdFire    = !arm_i && (state_q == DONE) && rd_req_i && (fill_q != '0);
    wrPtr_d   = wrPtr_q + 1'b1;
    fill_d    = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    rdPtrLoad = wrPtr_d - fill_d[DEPTH_LOG2-1:0];
`ifdef PCI_TRACE_TIMESTAMP_EN
    entry     = {tsCnt_q, sample};
`else
    entry     = sample;
`endif
  end

  always_ff @(posedge pci_clk_i) begin
    if (wrEn) mem[wrPtr_q] <= entry;
  end

  always_ff @(posedge pci_clk_i or negedge pci_rst_i) begin
    if (!pci_rst_i) begin
      state_q   <= IDLE;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      fill_q    <= '0;
      postCnt_q <= '0;
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
`ifdef PCI_TRACE_TIMESTAMP_EN
      tsCnt_q   <= '0;
`endif
    end else begin
      rdValid_q <= 1'b0;
`ifdef PCI_TRACE_TIMESTAMP_EN
      if (arm_i) tsCnt_q <= '0;
      else if (wrEn && tsCnt_q != 16'hFFFF) tsCnt_q <= tsCnt_q + 1'b1;
`endif
      if (arm_i) begin
        state_q   <= PRE;
        wrPtr_q   <= '0;
        rdPtr_q   <= '0;
        fill_q    <= '0;
        postCnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: ;
          PRE: begin
            wrPtr_q <= wrPtr_d;
            fill_q  <= fill_d;
            if (trigHit) begin
              postCnt_q <= POST_LOAD;
              if (POST_CLAMP == 0) begin
                state_q <= DONE;
                rdPtr_q <= rdPtrLoad;
              end else begin
                state_q <= POST;
              end
            end
          end
          POST: begin
            wrPtr_q   <= wrPtr_d;
            fill_q    <= fill_d;
            postCnt_q <= postCnt_q - 1'b1;
            if (postCnt_q == PTR_ONE) begin
              state_q <= DONE;
              rdPtr_q <= rdPtrLoad;
            end
          end
          DONE: begin
            if (rdFire) begin
              rdData_q  <= mem[rdPtr_q];
              rdValid_q <= 1'b1;
              rdPtr_q   <= rdPtr_q + 1'b1;
              fill_q    <= fill_q - 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign rd_data_o  = rdData_q;
  assign rd_valid_o = rdValid_q;
  assign rd_empty_o = (state_q != DONE) || (fill_q == '0);
  assign state_o    = state_q;

endmodule

// File: tb/tb_pci_trace_buf.sv
// tb_pci_trace_buf: directed scoreboard bench for pci_trace_buf (depth 16, four post-trigger samples).
module tb_pci_trace_buf;

  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 4;
  localparam int POST_TRIG  = 4;
  localparam int ENTRY_W    = DATA_W + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              irdy = 1'b1;
  logic              irdyEn = 1'b0;
  logic              trdy = 1'b1;
  logic [DATA_W-1:0] ad = '0;
  logic              arm = 1'b0;
  logic [DATA_W-1:0] trigMask = '0;
  logic [DATA_W-1:0] trigVal = '0;
  logic              rdReq = 1'b0;
  logic [ENTRY_W-1:0] rdData;
  logic              rdValid;
  logic              rdEmpty;
  logic [1:0]        state;

  int checksDone   = 0;
  int checksPassed = 0;
  int checksFailed = 0;
  logic [ENTRY_W-1:0] sbQ[$];

  pci_trace_buf #(
    .DATA_W(DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2),
    .POST_TRIG(POST_TRIG)
  ) dut (
    .pci_clk_i(clk),
    .pci_rst_i(rst_n),
    .pci_irdy_reg_i(irdy),
    .pci_irdy_en_reg_i(irdyEn),
    .pci_trdy_reg_i(trdy),
    .pci_ad_reg_i(ad),
    .arm_i(arm),
    .trig_mask_i(trigMask),
    .trig_val_i(trigVal),
    .rd_req_i(rdReq),
    .rd_data_o(rdData),
    .rd_valid_o(rdValid),
    .rd_empty_o(rdEmpty),
    .state_o(state)
  );

  always #5 clk = ~clk;

  function automatic logic [ENTRY_W-1:0] mkWord(input logic [DATA_W-1:0] a, input logic e,
                                                input logic i, input logic t);
    return {a, e, i, t};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checksDone++;
    assert (obs === exp) checksPassed++;
    else begin
      checksFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every cycle, any rd_valid pulse is matched against the oldest expected entry.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (rdValid === 1'b1) begin
      if (sbQ.size() == 0) checkOutput("unexpected_rd_valid", 64'(rdValid), 64'd0);
      else checkOutput("rd_data", 64'(rdData), 64'(sbQ.pop_front()));
    end
  endtask

  task automatic applyStimulus(input logic e, input logic i, input logic t, input logic [DATA_W-1:0] a);
    irdyEn = e;
    irdy   = i;
    trdy   = t;
    ad     = a;
    cycle();
  endtask

  task automatic armPulse();
    arm = 1'b1;
    cycle();
    arm = 1'b0;
  endtask

  task automatic readBurst(input int n);
    rdReq = 1'b1;
    repeat (n) cycle();
    rdReq = 1'b0;
    cycle();
    checkOutput("sb_drained", 64'(sbQ.size()), 64'd0);
    checkOutput("valid_after_burst", 64'(rdValid), 64'd0);
    checkOutput("empty_after_burst", 64'(rdEmpty), 64'd1);
  endtask

  initial begin
    #3;
    checkOutput("reset_state", 64'(state), 64'd0);
    checkOutput("reset_empty", 64'(rdEmpty), 64'd1);
    checkOutput("reset_valid", 64'(rdValid), 64'd0);
    checkOutput("reset_data", 64'(rdData), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    // Long capture: buffer wraps, window is AD 9..24.
    $display("[TB] wrap capture, trigger on AD=20");
    trigMask = 32'hFFFF_FFFF;
    trigVal  = 32'd20;
    armPulse();
    checkOutput("armed_state", 64'(state), 64'd1);
    checkOutput("pre_empty", 64'(rdEmpty), 64'd1);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, DATA_W'(i));
      if (i == 20) checkOutput("post_state", 64'(state), 64'd2);
      if (i == 24) checkOutput("done_state", 64'(state), 64'd3);
    end
    checkOutput("done_not_empty", 64'(rdEmpty), 64'd0);
    for (int i = 9; i <= 24; i++) sbQ.push_back(mkWord(DATA_W'(i), 1'b1, 1'b0, 1'b0));
    readBurst(17);
    checkOutput("data_holds", 64'(rdData), 64'(mkWord(32'd24, 1'b1, 1'b0, 1'b0)));

    // Early trigger: only 7 entries exist.
    $display("[TB] early trigger on AD=2");
    trigVal = 32'd2;
    armPulse();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, DATA_W'(i));
    checkOutput("early_done", 64'(state), 64'd3);
    for (int i = 0; i <= 6; i++) sbQ.push_back(mkWord(DATA_W'(i), 1'b1, 1'b0, 1'b0));
    readBurst(8);

    // IRDY# deasserted blocks the trigger; masked-off bit 0 difference does not.
    $display("[TB] trigger qualification");
    trigVal = 32'd5;
    armPulse();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd5);
    checkOutput("no_trig_irdy_high", 64'(state), 64'd1);
    trigMask = 32'h0000_FF00;
    trigVal  = 32'h0000_AB00;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_AB01);
    checkOutput("masked_trig", 64'(state), 64'd2);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h200 + DATA_W'(i));
    checkOutput("masked_done", 64'(state), 64'd3);
    sbQ.push_back(mkWord(32'd5, 1'b1, 1'b1, 1'b0));
    sbQ.push_back(mkWord(32'h0000_AB01, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) sbQ.push_back(mkWord(32'h200 + DATA_W'(i), 1'b1, 1'b0, 1'b0));
    readBurst(6);

    // Arm beats a same-cycle trigger, and restarts a partially read buffer.
    $display("[TB] arm priority");
    trigMask = 32'hFFFF_FFFF;
    trigVal  = 32'h50;
    armPulse();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h10);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h11);
    arm = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h50);
    arm = 1'b0;
    checkOutput("arm_over_trig", 64'(state), 64'd1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h50 + DATA_W'(i));
    checkOutput("rearm_done", 64'(state), 64'd3);
    for (int i = 0; i < 3; i++) sbQ.push_back(mkWord(32'h50 + DATA_W'(i), 1'b1, 1'b0, 1'b0));
    rdReq = 1'b1;
    repeat (3) cycle();
    rdReq = 1'b0;
    cycle();
    checkOutput("partial_drained", 64'(sbQ.size()), 64'd0);
    checkOutput("partial_not_empty", 64'(rdEmpty), 64'd0);
    arm   = 1'b1;
    rdReq = 1'b1;
    cycle();
    arm   = 1'b0;
    rdReq = 1'b0;
    checkOutput("arm_over_read_state", 64'(state), 64'd1);
    checkOutput("arm_over_read_valid", 64'(rdValid), 64'd0);
    checkOutput("arm_over_read_empty", 64'(rdEmpty), 64'd1);
    trigVal = 32'h70;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h70 + DATA_W'(i));
    checkOutput("restart_done", 64'(state), 64'd3);
    for (int i = 0; i < 5; i++) sbQ.push_back(mkWord(32'h70 + DATA_W'(i), 1'b1, 1'b0, 1'b0));
    readBurst(6);

    // Asynchronous reset in the middle of POST.
    $display("[TB] reset mid-POST");
    trigVal = 32'h30;
    armPulse();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h30);
    checkOutput("pre_reset_post", 64'(state), 64'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h31);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_state", 64'(state), 64'd0);
    checkOutput("async_reset_empty", 64'(rdEmpty), 64'd1);
    checkOutput("async_reset_valid", 64'(rdValid), 64'd0);
    checkOutput("async_reset_data", 64'(rdData), 64'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    trigVal = 32'h40;
    armPulse();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h40 + DATA_W'(i));
    checkOutput("after_reset_done", 64'(state), 64'd3);
    for (int i = 0; i < 5; i++) sbQ.push_back(mkWord(32'h40 + DATA_W'(i), 1'b1, 1'b0, 1'b0));
    readBurst(6);

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule

// File: doc/pci_trace_buf.md
Name: pci_trace_buf

Overview:
- Parametrised PCI-clock-domain debug capture buffer.
- Samples the registered PCI debug taps (irdy, irdy enable, trdy, AD backup) into a circular RAM each pci_clk cycle.
- Stops a programmable number of samples after a masked AD trigger; the captured window is then read out through a simple request/valid port.
- Sits beside pci_bridge32 in test tops, replacing ad-hoc single-stage tap registers with a multi-cycle pre/post-trigger trace.

Parameters:
- DATA_W, 32: width of the sampled AD bus.
- DEPTH_LOG2, 6: log2 of the buffer depth; depth = 2**DEPTH_LOG2 entries.
- POST_TRIG, 16: samples stored after the trigger sample. Legal range 0..2**DEPTH_LOG2-1; larger values are clamped to 2**DEPTH_LOG2-1.

Ports:
- pci_clk_i  in  1  PCI clock.
- pci_rst_i  in  1  asynchronous, active-low reset.
- pci_irdy_reg_i  in  1  registered IRDY# value.
- pci_irdy_en_reg_i  in  1  registered IRDY# output enable.
- pci_trdy_reg_i  in  1  registered TRDY# value.
- pci_ad_reg_i  in  DATA_W  registered AD backup value.
- arm_i  in  1  single-cycle pulse: clear buffer, start capture.
- trig_mask_i  in  DATA_W  AD compare mask (1 = bit compared).
- trig_val_i  in  DATA_W  AD compare value.
- rd_req_i  in  1  read next stored entry.
- rd_data_o  out  DATA_W+3 (+16 with the optional feature)  entry: {ad, irdy_en, irdy, trdy}, oldest first.
- rd_valid_o  out  1  rd_data_o valid, one-cycle pulse.
- rd_empty_o  out  1  no unread entries in DONE.
- state_o  out  2  00 IDLE, 01 PRE, 10 POST, 11 DONE.

Behaviour:
- Reset (pci_rst_i low, asynchronous):
  - state IDLE; wr_ptr, rd_ptr, fill count and post counter all 0.
  - Outputs: rd_data_o 0, rd_valid_o 0, rd_empty_o 1, state_o 00.
- Sample word: {pci_ad_reg_i, pci_irdy_en_reg_i, pci_irdy_reg_i, pci_trdy_reg_i}.
- Trigger condition (combinational): data phase (pci_irdy_en_reg_i & ~pci_irdy_reg_i & ~pci_trdy_reg_i) AND ((pci_ad_reg_i ^ trig_val_i) & trig_mask_i) == 0.
- IDLE: no writes. arm_i goes to PRE.
- PRE:
  - Write the sample at wr_ptr every cycle; wr_ptr wraps modulo depth.
  - Fill count increments and saturates at depth.
  - On trigger the trigger sample is written, the post counter is loaded with the clamped POST_TRIG, and the state goes to POST. If the clamped value is 0, go straight to DONE.
- POST:
  - Write every cycle; decrement the post counter.
  - The write that brings the counter to 0 is the last one; the state goes to DONE in the same cycle.
  - Further triggers are ignored.
- DONE:
  - No writes. rd_ptr is loaded on entry with (wr_ptr - fill count) mod depth, so the oldest entry is read first. The unread count equals the fill count.
  - rd_req_i with unread > 0: the RAM is read, rd_data_o updates and rd_valid_o pulses on the next cycle (latency 1), rd_ptr increments with wrap, unread decrements.
  - Back-to-back rd_req_i returns one entry per cycle.
  - rd_req_i with unread = 0 is ignored: no rd_valid_o, pointers hold.
- rd_empty_o:
  - 1 when state != DONE.
  - In DONE, 1 when unread = 0, updated in the same cycle the last read is issued.
- rd_data_o holds its last value between reads.
- arm_i in any state, including mid-PRE, mid-POST and mid-readout:
  - Clears pointers and counts, enters PRE next cycle.
  - Takes priority over a same-cycle trigger and a same-cycle rd_req_i; neither takes effect.
  - The sample in the arm cycle is not stored.
- Buffer: a single-port-per-side synchronous RAM is sufficient, since writes and reads never occur in the same state.

Optional Feature:
- PCI_TRACE_TIMESTAMP_EN defined:
  - A 16-bit counter clears on arm_i and increments every cycle in PRE/POST, saturating at 16'hFFFF.
  - Its value is stored with each sample in bits [DATA_W+18:DATA_W+3] of the entry and returned on rd_data_o.
- Macro undefined: no counter exists and rd_data_o is DATA_W+3 bits wide.

Test Plan:
- Reset mid-POST (DEPTH_LOG2=4, POST_TRIG=4) -> immediately state_o=00, rd_empty_o=1, rd_valid_o=0. A new arm_i then captures normally.
- Arm, drive AD=cycle index 0..29 in data phases, trigger on AD=20 (mask FFFFFFFF) -> DONE after 4 post samples. Reading 16 entries returns AD 9..24 in order. The 17th rd_req_i gives no rd_valid_o and rd_empty_o=1.
- Arm, trigger on the 3rd sample (AD=2), POST_TRIG=4 -> exactly 7 entries, AD 0..6, then empty.
- Trigger value present but IRDY# deasserted (irdy_reg=1), or only masked-off bits match (mask 0000FF00, AD differs in bit 0 only) -> the first case does not trigger; the second does trigger.
- arm_i in the same cycle as a trigger match, and arm_i during readout after 3 reads -> no trigger that cycle, state PRE, buffer restarted with fill count 0.
- With PCI_TRACE_TIMESTAMP_EN, trigger at cycle 10 after arm, POST_TRIG=2 -> the entry timestamps are consecutive, with the trigger entry holding 10. Without the macro, rd_data_o width is 35.
